// File: rtl/coincidence_recorder_pkg.sv
// coincidence_recorder_pkg: recorder CSR bit map, scan-controller status/command bit map
// and the scan FSM state type shared by the coincidence scan controller slice.
// Optional feature macro: COINCIDENCE_SCAN_AUTO_REALIGN_EN (adds the REALIGN state).
package coincidence_recorder_pkg;

   // Recorder CSR write-data fields
   localparam int REC_START_BIT       = 31;
   localparam int REC_COINCIDENCE_BIT = 30;
   localparam int REC_REALIGN_BIT     = 29;
   localparam int REC_MUXSEL_LSB      = 24;
   // Recorder CSR read-data fields
   localparam int REC_BUSY_BIT        = 31;

   localparam logic [31:0] REC_START_WORD   = 32'h1 << REC_START_BIT;
   localparam logic [31:0] REC_COIN_WORD    = 32'h1 << REC_COINCIDENCE_BIT;
   localparam logic [31:0] REC_REALIGN_WORD = 32'h1 << REC_REALIGN_BIT;

   // Host command fields written to this block
   localparam int HOST_START_BIT = 31;
   localparam int HOST_ABORT_BIT = 30;
   localparam int HOST_CHAN_LSB  = 24;

   // Status word fields read back by the host
   localparam int STAT_SCAN_BUSY_BIT = 31;
   localparam int STAT_TIMEOUT_BIT   = 30;
   localparam int STAT_NO_EDGE_BIT   = 29;
   localparam int STAT_FOUND_BIT     = 28;
   localparam int STAT_EDGE_W        = 16;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT_CLR,
      SEL,
      SETTLE,
      EVAL,
      COIN
`ifdef COINCIDENCE_SCAN_AUTO_REALIGN_EN
      , REALIGN
`endif
   } scanState_t;

endpackage

// File: rtl/coincidence_scan_controller_if.sv
// coincidence_scan_controller_if: one CSR port (write strobe, write data, read status).
// Used twice: host -> controller (controller is slave) and controller -> recorder (master).
interface coincidence_scan_controller_if;
   logic        csrStrobe;
   logic [31:0] gpioOut;
   logic [31:0] csr;

   modport master (output csrStrobe, output gpioOut, input csr);
   modport slave  (input csrStrobe, input gpioOut, output csr);
endinterface

// File: rtl/coincidence_scan_controller_bit_sync.sv
// bit_sync: two-flop synchronizer for a single level signal crossing into clk's domain.
module bit_sync (
   input  logic clk,
   input  logic rst,
   input  logic asyncIn,
   output logic syncOut
);
   (* ASYNC_REG = "TRUE" *) logic meta;
   (* ASYNC_REG = "TRUE" *) logic sync;

   // Two back-to-back flops give the first one a full cycle to resolve metastability.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= asyncIn;
         sync <= meta;
      end
   end

   assign syncOut = sync;
endmodule

// File: rtl/coincidence_scan_controller.sv
// coincidence_scan_controller: host-commanded sequencer that runs one recorder acquisition,
// reads every histogram bin of one channel (bin N-1 first as the wrap-around predecessor
// of bin 0), finds the lowest rising edge against a threshold and programs the recorder's
// coincidence sample count. Optional macro COINCIDENCE_SCAN_AUTO_REALIGN_EN appends a
// realign write after the coincidence write.
module coincidence_scan_controller
   import coincidence_recorder_pkg::*;
#(
   parameter int SAMPLE_CLKS_PER_COINCIDENCE = 80,
   parameter int CHANNEL_COUNT               = 2,
   parameter int SUM_WIDTH                   = 12,
   parameter int READ_SETTLE_CYCLES          = 8,
   parameter int ARM_TIMEOUT                 = 1024,
   parameter int ACQ_TIMEOUT                 = 16777215
) (
   input logic                           sysClk,
   input logic                           sysReset,
   coincidence_scan_controller_if.slave  sysBus,
   coincidence_scan_controller_if.master recBus
);
   localparam int N        = SAMPLE_CLKS_PER_COINCIDENCE;
   localparam int ADDR_W   = $clog2(N);
   localparam int MUXSEL_W = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
   localparam int TMR_MAX  = (ACQ_TIMEOUT > ARM_TIMEOUT) ? ACQ_TIMEOUT : ARM_TIMEOUT;
   localparam int TMR_W    = $clog2(TMR_MAX + 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

   scanState_t             state, stateN;
   logic [TMR_W-1:0]       tmr, tmrN;           // shared by arm/acquire timeouts, settle, realign gap
   logic [ADDR_W-1:0]      idx, idxN;
   logic                   prevPhase, prevPhaseN;
   logic                   prevHi, prevHiN;
   logic                   found, foundN;
   logic                   noEdge, noEdgeN;
   logic                   timeout, timeoutN;
   logic [STAT_EDGE_W-1:0] edgeIndex, edgeIndexN;
   logic [MUXSEL_W-1:0]    chan, chanN;
   logic [SUM_WIDTH-1:0]   thr, thrN;
   logic [SUM_WIDTH-1:0]   binCnt, binCntN;
   logic                   recStrobe, recStrobeN;
   logic [31:0]            recData, recDataN;
   logic [31:0]            selWord;
   logic                   busyS, hi, hostStart, hostAbort;
   logic                   unusedBits;

   bit_sync uBusySync (
      .clk     (sysClk),
      .rst     (sysReset),
      .asyncIn (recBus.csr[REC_BUSY_BIT]),
      .syncOut (busyS)
   );

   // Abort wins over a simultaneous start.
   assign hostAbort  = sysBus.csrStrobe && sysBus.gpioOut[HOST_ABORT_BIT];
   assign hostStart  = sysBus.csrStrobe && sysBus.gpioOut[HOST_START_BIT] && !hostAbort;
   assign hi         = (binCnt >= thr);
   assign unusedBits = ^{sysBus.gpioOut, recBus.csr};

   // Bin-select word: channel mux field plus bin index, everything else zero.
   always_comb begin
      selWord = '0;
      selWord[REC_MUXSEL_LSB +: MUXSEL_W] = chan;
      selWord[ADDR_W-1:0]                 = idx;
   end

   // Host-visible status word.
   always_comb begin
      sysBus.csr                     = '0;
      sysBus.csr[STAT_SCAN_BUSY_BIT] = (state != IDLE);
      sysBus.csr[STAT_TIMEOUT_BIT]   = timeout;
      sysBus.csr[STAT_NO_EDGE_BIT]   = noEdge;
      sysBus.csr[STAT_FOUND_BIT]     = found;
      sysBus.csr[STAT_EDGE_W-1:0]    = edgeIndex;
   end

   assign recBus.csrStrobe = recStrobe;
   assign recBus.gpioOut   = recData;

   // Next-state, counter and recorder-write decisions for the scan sequence.
   always_comb begin
      // NOTE: every variable gets its hold/default value first so no path can infer a latch.
      stateN     = state;
      tmrN       = tmr;
      idxN       = idx;
      prevPhaseN = prevPhase;
      prevHiN    = prevHi;
      foundN     = found;
      noEdgeN    = noEdge;
      timeoutN   = timeout;
      edgeIndexN = edgeIndex;
      chanN      = chan;
      thrN       = thr;
      binCntN    = binCnt;
      recStrobeN = 1'b0;
      recDataN   = recData;

      case (state)
         IDLE: if (hostStart) begin
            stateN   = ARM;
            tmrN     = '0;
            chanN    = sysBus.gpioOut[HOST_CHAN_LSB +: MUXSEL_W];
            thrN     = sysBus.gpioOut[SUM_WIDTH-1:0];
            timeoutN = 1'b0;
            noEdgeN  = 1'b0;
            foundN   = 1'b0;
         end
         // First ARM cycle issues the start write, which keeps a gap after any prior strobe.
         ARM: begin
            if (tmr == '0) begin
               recStrobeN = 1'b1;
               recDataN   = REC_START_WORD;
               tmrN       = TMR_W'(1);
            end else if (busyS) begin
               stateN = WAIT_CLR;
               tmrN   = '0;
            end else if (tmr == TMR_W'(ARM_TIMEOUT)) begin
               timeoutN = 1'b1;
               stateN   = IDLE;
            end else begin
               tmrN = tmr + 1'b1;
            end
         end
         WAIT_CLR: begin
            if (!busyS) begin
               stateN     = SEL;
               idxN       = LAST_IDX;
               prevPhaseN = 1'b1;
            end else if (tmr == TMR_W'(ACQ_TIMEOUT - 1)) begin
               timeoutN = 1'b1;
               stateN   = IDLE;
            end else begin
               tmrN = tmr + 1'b1;
            end
         end
         SEL: begin
            recStrobeN = 1'b1;
            recDataN   = selWord;
            tmrN       = '0;
            stateN     = SETTLE;
         end
         SETTLE: begin
            if (tmr == TMR_W'(READ_SETTLE_CYCLES - 1)) begin
               binCntN = recBus.csr[SUM_WIDTH-1:0];
               stateN  = EVAL;
            end else begin
               tmrN = tmr + 1'b1;
            end
         end
         EVAL: begin
            prevHiN = hi;
            if (prevPhase) begin
               idxN       = '0;
               prevPhaseN = 1'b0;
               stateN     = SEL;
            end else begin
               if (!found && hi && !prevHi) begin
                  foundN     = 1'b1;
                  edgeIndexN = STAT_EDGE_W'(idx);
               end
               if (idx == LAST_IDX) begin
                  if (foundN) begin
                     stateN = COIN;
                  end else begin
                     noEdgeN = 1'b1;
                     stateN  = IDLE;
                  end
               end else begin
                  idxN   = idx + 1'b1;
                  stateN = SEL;
               end
            end
         end
         COIN: begin
            recStrobeN = 1'b1;
            recDataN   = REC_COIN_WORD | 32'(edgeIndex);
`ifdef COINCIDENCE_SCAN_AUTO_REALIGN_EN
            tmrN       = '0;
            stateN     = REALIGN;
`else
            stateN     = IDLE;
`endif
         end
`ifdef COINCIDENCE_SCAN_AUTO_REALIGN_EN
         // One quiet cycle after the coincidence write, then the realign write.
         REALIGN: begin
            if (tmr == '0) begin
               tmrN = TMR_W'(1);
            end else begin
               recStrobeN = 1'b1;
               recDataN   = REC_REALIGN_WORD;
               stateN     = IDLE;
            end
         end
`endif
         default: stateN = IDLE;
      endcase

      // Abort drops to IDLE with no further writes and leaves the status flags as they were.
      if (hostAbort) begin
         stateN     = IDLE;
         recStrobeN = 1'b0;
         recDataN   = recData;
         foundN     = found;
         noEdgeN    = noEdge;
         timeoutN   = timeout;
         edgeIndexN = edgeIndex;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge sysClk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (sysReset) begin
         state     <= IDLE;
         tmr       <= '0;
         idx       <= '0;
         prevPhase <= 1'b0;
         prevHi    <= 1'b0;
         found     <= 1'b0;
         noEdge    <= 1'b0;
         timeout   <= 1'b0;
         edgeIndex <= '0;
         chan      <= '0;
         thr       <= '0;
         binCnt    <= '0;
         recStrobe <= 1'b0;
         recData   <= '0;
      end else begin
         state     <= stateN;
         tmr       <= tmrN;
         idx       <= idxN;
         prevPhase <= prevPhaseN;
         prevHi    <= prevHiN;
         found     <= foundN;
         noEdge    <= noEdgeN;
         timeout   <= timeoutN;
         edgeIndex <= edgeIndexN;
         chan      <= chanN;
         thr       <= thrN;
         binCnt    <= binCntN;
         recStrobe <= recStrobeN;
         recData   <= recDataN;
      end
   end

endmodule
